// File: rtl/wbmaster_burst_pkg.sv
// Shared types for the burst Wishbone master: FSM states, status codes, default widths.
package wbmaster_burst_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_WD = 2'd1,
        ST_BUS     = 2'd2,
        ST_DONE    = 2'd3
    } wbm_state_e;

    typedef enum logic [1:0] {
        WBM_ST_OK  = 2'b00,
        WBM_ST_ERR = 2'b01,
        WBM_ST_TMO = 2'b10
    } wbm_status_e;

    localparam int WBM_AW_DEF      = 8;
    localparam int WBM_DW_DEF      = 8;
    localparam int WBM_SW_DEF      = 1;
    localparam int WBM_LW_DEF      = 4;
    localparam int WBM_TIMEOUT_DEF = 16;

endpackage

// File: rtl/wbmaster_burst_wbm_watchdog.sv
// Bus-phase watchdog: counts cycles without a termination and flags expiry at TIMEOUT-1.
module wbmaster_burst_wbm_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic run_i,
    input  logic clr_i,
    output logic expire_o
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (!run_i || clr_i) cnt_d = '0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign expire_o = run_i && !clr_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/wbmaster_burst.sv
// Wishbone classic master running single/incrementing bursts from a local command port.
// Optional watchdog enabled with `define WBM_TIMEOUT_EN.
module wbmaster_burst
    import wbmaster_burst_pkg::*;
#(
    parameter int AW      = WBM_AW_DEF,
    parameter int DW      = WBM_DW_DEF,
    parameter int SW      = WBM_SW_DEF,
    parameter int LW      = WBM_LW_DEF,
    parameter int ADR_INC = 1,
    parameter int TIMEOUT = WBM_TIMEOUT_DEF
) (
    input  logic          CLK_I,
    input  logic          RST_N_I,
    input  logic          CMD_VALID_I,
    output logic          CMD_READY_O,
    input  logic [AW-1:0] CMD_ADR_I,
    input  logic          CMD_WE_I,
    input  logic [SW-1:0] CMD_SEL_I,
    input  logic [LW-1:0] CMD_LEN_I,
    input  logic          WD_VALID_I,
    input  logic [DW-1:0] WD_DAT_I,
    output logic          WD_READY_O,
    output logic          RD_VALID_O,
    output logic [DW-1:0] RD_DAT_O,
    output logic          DONE_O,
    output logic [1:0]    STATUS_O,
    output logic [AW-1:0] ADR_O,
    output logic [DW-1:0] DAT_O,
    output logic          WE_O,
    output logic [SW-1:0] SEL_O,
    output logic          STB_O,
    output logic          CYC_O,
    input  logic [DW-1:0] DAT_I,
    input  logic          ACK_I,
    input  logic          ERR_I,
    input  logic          INTR_I,
    input  logic          IRQ_CLR_I,
    output logic          IRQ_PEND_O
);

    wbm_state_e    state_q, state_d;
    wbm_status_e   status_q, status_d;
    logic [AW-1:0] adr_q, adr_d;
    logic          we_q, we_d;
    logic [SW-1:0] sel_q, sel_d;
    logic [LW-1:0] beats_q, beats_d;
    logic [DW-1:0] dat_q, dat_d;
    logic          mid_q, mid_d;
    logic          rd_vld_q, rd_vld_d;
    logic [DW-1:0] rd_dat_q, rd_dat_d;
    logic          irq_q, irq_d;
    logic          wd_expire;

`ifdef WBM_TIMEOUT_EN
    wbmaster_burst_wbm_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk_i    (CLK_I),
        .rst_n_i  (RST_N_I),
        .run_i    (state_q == ST_BUS),
        .clr_i    (ACK_I | ERR_I),
        .expire_o (wd_expire)
    );
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT);
    assign wd_expire      = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        adr_d    = adr_q;
        we_d     = we_q;
        sel_d    = sel_q;
        beats_d  = beats_q;
        dat_d    = dat_q;
        mid_d    = mid_q;
        rd_vld_d = 1'b0;
        rd_dat_d = rd_dat_q;
        // set beats clear when both arrive together
        irq_d    = INTR_I ? 1'b1 : (IRQ_CLR_I ? 1'b0 : irq_q);

        case (state_q)
            ST_IDLE: begin
                mid_d = 1'b0;
                if (CMD_VALID_I) begin
                    adr_d   = CMD_ADR_I;
                    we_d    = CMD_WE_I;
                    sel_d   = CMD_SEL_I;
                    beats_d = CMD_LEN_I;
                    state_d = CMD_WE_I ? ST_WAIT_WD : ST_BUS;
                end
            end
            ST_WAIT_WD: begin
                if (WD_VALID_I) begin
                    dat_d   = WD_DAT_I;
                    state_d = ST_BUS;
                end
            end
            ST_BUS: begin
                if (ERR_I) begin
                    status_d = WBM_ST_ERR;
                    state_d  = ST_DONE;
                end else if (ACK_I) begin
                    if (!we_q) begin
                        rd_vld_d = 1'b1;
                        rd_dat_d = DAT_I;
                    end
                    if (beats_q == '0) begin
                        status_d = WBM_ST_OK;
                        state_d  = ST_DONE;
                    end else begin
                        adr_d   = adr_q + AW'(ADR_INC);
                        beats_d = beats_q - LW'(1);
                        mid_d   = 1'b1;
                        if (we_q) state_d = ST_WAIT_WD;
                    end
                end else if (wd_expire) begin
                    status_d = WBM_ST_TMO;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                mid_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            state_q  <= ST_IDLE;
            status_q <= WBM_ST_OK;
            adr_q    <= '0;
            we_q     <= 1'b0;
            sel_q    <= '0;
            beats_q  <= '0;
            dat_q    <= '0;
            mid_q    <= 1'b0;
            rd_vld_q <= 1'b0;
            rd_dat_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            adr_q    <= adr_d;
            we_q     <= we_d;
            sel_q    <= sel_d;
            beats_q  <= beats_d;
            dat_q    <= dat_d;
            mid_q    <= mid_d;
            rd_vld_q <= rd_vld_d;
            rd_dat_q <= rd_dat_d;
            irq_q    <= irq_d;
        end
    end

    // Bus strobes decode straight from state so reset releases the bus without a clock edge.
    assign CMD_READY_O = (state_q == ST_IDLE);
    assign WD_READY_O  = (state_q == ST_WAIT_WD);
    assign STB_O       = (state_q == ST_BUS);
    assign CYC_O       = (state_q == ST_BUS) || ((state_q == ST_WAIT_WD) && mid_q);
    assign DONE_O      = (state_q == ST_DONE);
    assign STATUS_O    = status_q;
    assign ADR_O       = adr_q;
    assign DAT_O       = dat_q;
    assign WE_O        = we_q;
    assign SEL_O       = sel_q;
    assign RD_VALID_O  = rd_vld_q;
    assign RD_DAT_O    = rd_dat_q;
    assign IRQ_PEND_O  = irq_q;

endmodule

// File: tb/tb_wbmaster_burst.sv
// Self-checking bench for wbmaster_burst: scripted scenarios plus randomized bursts vs a queue model.
module tb_wbmaster_burst;

    logic       CLK_I = 1'b0, RST_N_I = 1'b0;
    logic       CMD_VALID_I = 1'b0, CMD_WE_I = 1'b0, WD_VALID_I, ACK_I, ERR_I;
    logic [7:0] CMD_ADR_I = '0, WD_DAT_I, DAT_I, RD_DAT_O, ADR_O, DAT_O;
    logic [0:0] CMD_SEL_I = '0, SEL_O;
    logic [3:0] CMD_LEN_I = '0;
    logic       INTR_I = 1'b0, IRQ_CLR_I = 1'b0;
    logic       CMD_READY_O, WD_READY_O, RD_VALID_O, DONE_O, WE_O, STB_O, CYC_O, IRQ_PEND_O;
    logic [1:0] STATUS_O;

    wbmaster_burst dut (
        .CLK_I(CLK_I), .RST_N_I(RST_N_I), .CMD_VALID_I(CMD_VALID_I), .CMD_READY_O(CMD_READY_O),
        .CMD_ADR_I(CMD_ADR_I), .CMD_WE_I(CMD_WE_I), .CMD_SEL_I(CMD_SEL_I), .CMD_LEN_I(CMD_LEN_I),
        .WD_VALID_I(WD_VALID_I), .WD_DAT_I(WD_DAT_I), .WD_READY_O(WD_READY_O),
        .RD_VALID_O(RD_VALID_O), .RD_DAT_O(RD_DAT_O), .DONE_O(DONE_O), .STATUS_O(STATUS_O),
        .ADR_O(ADR_O), .DAT_O(DAT_O), .WE_O(WE_O), .SEL_O(SEL_O), .STB_O(STB_O), .CYC_O(CYC_O),
        .DAT_I(DAT_I), .ACK_I(ACK_I), .ERR_I(ERR_I), .INTR_I(INTR_I), .IRQ_CLR_I(IRQ_CLR_I),
        .IRQ_PEND_O(IRQ_PEND_O)
    );

    always #5 CLK_I = ~CLK_I;

    int n_chk = 0, n_pass = 0, cyc = 0;
    logic [7:0] mem [256];
    int cfg_wait = 0, cfg_err_beat = -1, cur_wait = 0, beat_idx = 0, wcnt = 0;
    bit cfg_err_ack = 0, cfg_mute = 0, cfg_rnd = 0, cfg_wd_gaps = 0;
    logic [7:0] wq[$], rlog[$], alog[$], wlog[$];
    int rcyc[$], ack_cyc[$];
    int done_cnt = 0, done_cyc = 0, stb_rise_cyc = 0, cyc_hi_done = 0, stb_in_wd = 0, cyc_gap = 0;
    logic [1:0] done_st = 2'b00;
    bit stb_prev = 0, stb_seen = 0;

    initial forever begin @(posedge CLK_I); cyc++; end

    // Bus slave, write-data source and monitor; everything acts on the falling edge.
    initial begin
        ACK_I = 0; ERR_I = 0; DAT_I = 0; WD_VALID_I = 0; WD_DAT_I = 0;
        forever begin
            @(negedge CLK_I);
            if (RD_VALID_O) begin rlog.push_back(RD_DAT_O); rcyc.push_back(cyc); end
            if (DONE_O) begin
                done_cnt++; done_cyc = cyc; done_st = STATUS_O; stb_seen = 0;
                if (CYC_O || STB_O) cyc_hi_done++;
            end
            if (stb_seen && !CYC_O) cyc_gap++;
            if (STB_O) stb_seen = 1;
            if (STB_O && !stb_prev) stb_rise_cyc = cyc;
            stb_prev = STB_O;
            if (STB_O && WD_READY_O) stb_in_wd++;
            ACK_I = 0; ERR_I = 0;
            if (STB_O && !cfg_mute) begin
                if (wcnt >= cur_wait) begin
                    wcnt = 0;
                    alog.push_back(ADR_O); ack_cyc.push_back(cyc);
                    DAT_I = mem[ADR_O];
                    if (beat_idx == cfg_err_beat) begin ERR_I = 1; ACK_I = cfg_err_ack; end
                    else begin ACK_I = 1; if (WE_O) wlog.push_back(DAT_O); end
                    beat_idx++;
                    cur_wait = cfg_rnd ? int'($urandom_range(0, 3)) : cfg_wait;
                end else wcnt++;
            end else wcnt = 0;
            WD_VALID_I = (wq.size() > 0) && !(cfg_wd_gaps && $urandom_range(0, 2) == 0);
            WD_DAT_I   = (wq.size() > 0) ? wq[0] : 8'h00;
            if (WD_VALID_I && WD_READY_O) void'(wq.pop_front());
        end
    end

    task automatic start_cmd(input logic [7:0] adr, input bit we, input logic [3:0] len, input logic sel);
        rlog.delete(); alog.delete(); wlog.delete(); rcyc.delete(); ack_cyc.delete();
        beat_idx = 0; wcnt = 0; cur_wait = cfg_rnd ? int'($urandom_range(0, 3)) : cfg_wait;
        cyc_gap = 0; stb_in_wd = 0;
        @(negedge CLK_I); #1;
        CMD_VALID_I = 1; CMD_ADR_I = adr; CMD_WE_I = we; CMD_LEN_I = len; CMD_SEL_I = sel;
        n_chk++; if (CMD_READY_O !== 1'b1) $display("FAIL cmd_ready_idle: got %b want 1", CMD_READY_O); else n_pass++;
        @(posedge CLK_I); #1;
        CMD_VALID_I = 0;
    endtask

    task automatic wait_done(input int limit, input string nm);
        int d0 = done_cnt;
        bit ok = 0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge CLK_I); #1;
            if (done_cnt != d0) ok = 1;
        end
        n_chk++; if (!ok) $display("FAIL %s_done: no DONE_O within %0d cycles", nm, limit); else n_pass++;
    endtask

    task automatic test_reset();
        RST_N_I = 0; #1;
        n_chk++;
        if ({CMD_READY_O, CYC_O, STB_O, DONE_O, RD_VALID_O, WD_READY_O, IRQ_PEND_O, WE_O} !== 8'b1000_0000)
            $display("FAIL reset_ctrl: got %b want 10000000",
                     {CMD_READY_O, CYC_O, STB_O, DONE_O, RD_VALID_O, WD_READY_O, IRQ_PEND_O, WE_O});
        else n_pass++;
        n_chk++;
        if ({STATUS_O, ADR_O, DAT_O, SEL_O, RD_DAT_O} !== 27'd0)
            $display("FAIL reset_data: got %h want 0", {STATUS_O, ADR_O, DAT_O, SEL_O, RD_DAT_O});
        else n_pass++;
        repeat (3) @(negedge CLK_I);
        RST_N_I = 1;
    endtask

    task automatic test_single_read();
        mem[8'h10] = 8'hF0; cfg_wait = 2; cfg_err_beat = -1; cfg_rnd = 0;
        start_cmd(8'h10, 0, 4'd0, 1'b1);
        wait_done(50, "single_read");
        n_chk++; if (rlog.size() != 1) $display("FAIL single_read_cnt: got %0d want 1", rlog.size()); else n_pass++;
        n_chk++; if ((rlog.size() > 0 ? rlog[0] : 8'hxx) !== 8'hF0)
            $display("FAIL single_read_data: got %h want f0", rlog.size() > 0 ? rlog[0] : 8'hxx); else n_pass++;
        n_chk++; if ((rcyc.size() > 0 && ack_cyc.size() > 0 ? rcyc[0] - ack_cyc[0] : -1) != 1)
            $display("FAIL single_read_latency: rd at %0d, ack at %0d, want +1",
                     rcyc.size() > 0 ? rcyc[0] : -1, ack_cyc.size() > 0 ? ack_cyc[0] : -1); else n_pass++;
        n_chk++; if ((ack_cyc.size() > 0 ? ack_cyc[0] - stb_rise_cyc : -1) != 2)
            $display("FAIL single_read_waits: got %0d want 2", ack_cyc.size() > 0 ? ack_cyc[0] - stb_rise_cyc : -1); else n_pass++;
        n_chk++; if (done_st !== 2'b00) $display("FAIL single_read_status: got %b want 00", done_st); else n_pass++;
        n_chk++; if (cyc_hi_done != 0) $display("FAIL done_cyc_low: CYC/STB high in %0d DONE cycles, want 0", cyc_hi_done); else n_pass++;
    endtask

    task automatic test_write_burst_wrap();
        logic [7:0] wd [4];
        wd[0] = 8'h11; wd[1] = 8'h22; wd[2] = 8'h33; wd[3] = 8'h44;
        cfg_wait = 0; cfg_err_beat = -1;
        start_cmd(8'hFE, 1, 4'd3, 1'b1);
        wq.delete(); for (int i = 0; i < 4; i++) wq.push_back(wd[i]);
        wait_done(60, "wr_burst");
        n_chk++; if (alog.size() != 4) $display("FAIL wr_burst_beats: got %0d want 4", alog.size()); else n_pass++;
        for (int i = 0; i < 4 && i < alog.size(); i++) begin
            logic [7:0] ea = 8'(254 + i);
            n_chk++; if (alog[i] !== ea) $display("FAIL wr_burst_adr%0d: got %h want %h", i, alog[i], ea); else n_pass++;
        end
        for (int i = 0; i < 4 && i < wlog.size(); i++) begin
            n_chk++; if (wlog[i] !== wd[i]) $display("FAIL wr_burst_dat%0d: got %h want %h", i, wlog[i], wd[i]); else n_pass++;
        end
        n_chk++; if (cyc_gap != 0) $display("FAIL wr_burst_cyc_held: CYC low %0d cycles, want 0", cyc_gap); else n_pass++;
        n_chk++; if (stb_in_wd != 0) $display("FAIL wr_burst_stb_in_wd: %0d cycles, want 0", stb_in_wd); else n_pass++;
        n_chk++; if (done_st !== 2'b00) $display("FAIL wr_burst_status: got %b want 00", done_st); else n_pass++;
    endtask

    task automatic test_read_err();
        cfg_wait = 1; cfg_err_beat = 1; cfg_err_ack = 0;
        start_cmd(8'h10, 0, 4'd3, 1'b1);
        wait_done(60, "rd_err");
        n_chk++; if (rlog.size() != 1) $display("FAIL rd_err_cnt: got %0d want 1", rlog.size()); else n_pass++;
        n_chk++; if ((rlog.size() > 0 ? rlog[0] : 8'hxx) !== mem[8'h10])
            $display("FAIL rd_err_data: got %h want %h", rlog.size() > 0 ? rlog[0] : 8'hxx, mem[8'h10]); else n_pass++;
        n_chk++; if (done_st !== 2'b01) $display("FAIL rd_err_status: got %b want 01", done_st); else n_pass++;
        n_chk++; if (ADR_O !== 8'h11) $display("FAIL rd_err_adr: got %h want 11", ADR_O); else n_pass++;
    endtask

    task automatic test_ack_err_same();
        cfg_wait = 0; cfg_err_beat = 0; cfg_err_ack = 1;
        start_cmd(8'h33, 0, 4'd2, 1'b1);
        wait_done(40, "ack_err");
        n_chk++; if (rlog.size() != 0) $display("FAIL ack_err_nodata: got %0d beats want 0", rlog.size()); else n_pass++;
        n_chk++; if (done_st !== 2'b01) $display("FAIL ack_err_status: got %b want 01", done_st); else n_pass++;
        cfg_err_ack = 0; cfg_err_beat = -1;
    endtask

    task automatic test_timeout();
        int d0;
        cfg_mute = 1;
        d0 = done_cnt;
        start_cmd(8'h40, 0, 4'd0, 1'b1);
`ifdef WBM_TIMEOUT_EN
        wait_done(40, "timeout");
        n_chk++; if (done_cyc - stb_rise_cyc != 16)
            $display("FAIL timeout_delay: got %0d want 16", done_cyc - stb_rise_cyc); else n_pass++;
        n_chk++; if (done_st !== 2'b10) $display("FAIL timeout_status: got %b want 10", done_st); else n_pass++;
`else
        repeat (40) @(negedge CLK_I);
        n_chk++; if ({CYC_O, STB_O} !== 2'b11) $display("FAIL no_timeout_stb_held: got %b want 11", {CYC_O, STB_O}); else n_pass++;
        n_chk++; if (done_cnt != d0) $display("FAIL no_timeout_done: got %0d DONEs want 0", done_cnt - d0); else n_pass++;
        RST_N_I = 0; @(negedge CLK_I); RST_N_I = 1;
`endif
        cfg_mute = 0;
    endtask

    task automatic test_reset_mid_burst();
        int d0 = done_cnt;
        cfg_mute = 1;
        start_cmd(8'h80, 0, 4'd5, 1'b1);
        repeat (3) @(negedge CLK_I);
        n_chk++; if (STB_O !== 1'b1) $display("FAIL rst_mid_pre_stb: got %b want 1", STB_O); else n_pass++;
        @(posedge CLK_I); #2;
        RST_N_I = 0; #1;
        n_chk++; if ({CYC_O, STB_O} !== 2'b00) $display("FAIL rst_mid_async_release: got %b want 00", {CYC_O, STB_O}); else n_pass++;
        repeat (2) @(negedge CLK_I);
        RST_N_I = 1; cfg_mute = 0; #1;
        n_chk++; if (CMD_READY_O !== 1'b1) $display("FAIL rst_mid_ready: got %b want 1", CMD_READY_O); else n_pass++;
        repeat (3) @(negedge CLK_I);
        n_chk++; if (done_cnt != d0) $display("FAIL rst_mid_no_done: got %0d DONEs want 0", done_cnt - d0); else n_pass++;
    endtask

    task automatic test_irq();
        @(negedge CLK_I); #1; INTR_I = 1; IRQ_CLR_I = 1;
        @(negedge CLK_I); #1;
        n_chk++; if (IRQ_PEND_O !== 1'b1) $display("FAIL irq_set_wins: got %b want 1", IRQ_PEND_O); else n_pass++;
        INTR_I = 0; IRQ_CLR_I = 0;
        @(negedge CLK_I); #1;
        n_chk++; if (IRQ_PEND_O !== 1'b1) $display("FAIL irq_sticky: got %b want 1", IRQ_PEND_O); else n_pass++;
        IRQ_CLR_I = 1;
        @(negedge CLK_I); #1;
        n_chk++; if (IRQ_PEND_O !== 1'b0) $display("FAIL irq_clear: got %b want 0", IRQ_PEND_O); else n_pass++;
        IRQ_CLR_I = 0;
    endtask

    task automatic test_random_bursts();
        cfg_rnd = 1; cfg_wd_gaps = 1;
        for (int n = 0; n < 24; n++) begin
            logic [7:0] adr = 8'($urandom);
            bit         we  = 1'($urandom);
            logic [3:0] len = 4'($urandom_range(0, 15));
            logic [7:0] ew[$];
            int nterm, nack;
            cfg_err_beat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(len))) : -1;
            cfg_err_ack  = 1'($urandom);
            for (int i = 0; i <= int'(len); i++) ew.push_back(8'($urandom));
            // model: beats before the error complete; the error beat itself terminates but carries nothing
            nack  = (cfg_err_beat >= 0) ? cfg_err_beat : int'(len) + 1;
            nterm = (cfg_err_beat >= 0) ? cfg_err_beat + 1 : int'(len) + 1;
            start_cmd(adr, we, len, 1'($urandom));
            wq.delete(); if (we) wq = ew;
            wait_done(400, "rnd");
            n_chk++; if (alog.size() != nterm) $display("FAIL rnd%0d_beats: got %0d want %0d", n, alog.size(), nterm); else n_pass++;
            for (int i = 0; i < alog.size() && i < nterm; i++) begin
                logic [7:0] ea = 8'(int'(adr) + i);
                n_chk++; if (alog[i] !== ea) $display("FAIL rnd%0d_adr%0d: got %h want %h", n, i, alog[i], ea); else n_pass++;
            end
            n_chk++; if ((we ? wlog.size() : rlog.size()) != nack)
                $display("FAIL rnd%0d_data_cnt: got %0d want %0d", n, we ? wlog.size() : rlog.size(), nack); else n_pass++;
            for (int i = 0; i < nack; i++) begin
                logic [7:0] exp_d = we ? ew[i] : mem[8'(int'(adr) + i)];
                logic [7:0] got_d = we ? (i < wlog.size() ? wlog[i] : 8'hxx) : (i < rlog.size() ? rlog[i] : 8'hxx);
                n_chk++; if (got_d !== exp_d) $display("FAIL rnd%0d_dat%0d: got %h want %h", n, i, got_d, exp_d); else n_pass++;
            end
            n_chk++; if (done_st !== (cfg_err_beat >= 0 ? 2'b01 : 2'b00))
                $display("FAIL rnd%0d_status: got %b want %b", n, done_st, cfg_err_beat >= 0 ? 2'b01 : 2'b00); else n_pass++;
        end
        cfg_rnd = 0; cfg_wd_gaps = 0; cfg_err_beat = -1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        test_reset();
        test_single_read();
        test_write_burst_wrap();
        test_read_err();
        test_ack_err_same();
        test_timeout();
        test_reset_mid_burst();
        test_irq();
        test_random_bursts();
        n_chk++; if (cyc_hi_done != 0) $display("FAIL done_cyc_low_all: %0d DONE cycles with bus held", cyc_hi_done); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
